// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle RISC-V controller: FSM states, opcodes,
// ALU operation codes and datapath mux selects.
package multicycle_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL, S_ERROR
  } state_t;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_BAD = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic ADR_PC     = 1'b0;
  localparam logic ADR_RESULT = 1'b1;

endpackage

// File: rtl/alu_decoder.sv
// Maps the FSM's coarse ALU request plus funct fields to the ALU control code.
module alu_decoder
  import multicycle_controller_pkg::*;
(
  input  logic [1:0] i_alu_op,
  input  logic [2:0] i_funct3,
  input  logic       i_op5,
  input  logic       i_funct7b5,
  output logic [2:0] o_alu_control
);

  always_comb begin
    o_alu_control = ALU_BAD;
    case (i_alu_op)
      ALUOP_ADD: o_alu_control = ALU_ADD;
      ALUOP_SUB: o_alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (i_funct3)
          3'b000:  o_alu_control = (i_op5 & i_funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  o_alu_control = ALU_SLT;
          3'b110:  o_alu_control = ALU_OR;
          3'b111:  o_alu_control = ALU_AND;
          default: o_alu_control = ALU_BAD;
        endcase
      end
      default: o_alu_control = ALU_BAD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing a multicycle RISC-V datapath (lw/sw/R/I/beq/jal).
// Write enables are gated by rst_n so nothing is written while reset is held.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter bit ILLEGAL_TRAP = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic [2:0] ALUControl,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       illegal
);

  state_t     r_state;
  state_t     w_next_state;
  logic [1:0] w_alu_op;
  logic       w_pc_update, w_branch, w_irwrite, w_regwrite, w_memwrite, w_illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_alu_op     = ALUOP_ADD;
    ALUSrcA      = SRCA_PC;
    ALUSrcB      = SRCB_RS2;
    ResultSrc    = RES_ALUOUT;
    AdrSrc       = ADR_PC;
    w_pc_update  = 1'b0;
    w_branch     = 1'b0;
    w_irwrite    = 1'b0;
    w_regwrite   = 1'b0;
    w_memwrite   = 1'b0;
    w_illegal    = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_irwrite    = 1'b1;
        ALUSrcB      = SRCB_FOUR;
        ResultSrc    = RES_ALU;
        w_pc_update  = 1'b1;
        w_next_state = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LW, OP_SW: w_next_state = S_MEMADR;
          OP_RTYPE:     w_next_state = S_EXECR;
          OP_ITYPE:     w_next_state = S_EXECI;
          OP_BEQ:       w_next_state = S_BEQ;
          OP_JAL:       w_next_state = S_JAL;
          default:      w_next_state = ILLEGAL_TRAP ? S_ERROR : S_FETCH;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA      = SRCA_RS1;
        ALUSrcB      = SRCB_IMM;
        w_next_state = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc       = ADR_RESULT;
        w_next_state = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc    = RES_MEM;
        w_regwrite   = 1'b1;
        w_next_state = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc       = ADR_RESULT;
        w_memwrite   = 1'b1;
        w_next_state = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA      = SRCA_RS1;
        w_alu_op     = ALUOP_FUNCT;
        w_next_state = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA      = SRCA_RS1;
        ALUSrcB      = SRCB_IMM;
        w_alu_op     = ALUOP_FUNCT;
        w_next_state = S_ALUWB;
      end
      S_ALUWB: begin
        w_regwrite   = 1'b1;
        w_next_state = S_FETCH;
      end
      S_BEQ: begin
        ALUSrcA      = SRCA_RS1;
        w_alu_op     = ALUOP_SUB;
        w_branch     = 1'b1;
        w_next_state = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA      = SRCA_OLDPC;
        ALUSrcB      = SRCB_FOUR;
        w_pc_update  = 1'b1;
        w_next_state = S_ALUWB;
      end
      S_ERROR: begin
        w_illegal    = 1'b1;
        w_next_state = S_ERROR;
      end
      default: w_next_state = S_FETCH;
    endcase
  end

  always_comb begin
    ImmSrc = IMM_I;
    case (op)
      OP_SW:   ImmSrc = IMM_S;
      OP_BEQ:  ImmSrc = IMM_B;
      OP_JAL:  ImmSrc = IMM_J;
      default: ImmSrc = IMM_I;
    endcase
  end

  alu_decoder u_alu_decoder (
    .i_alu_op      (w_alu_op),
    .i_funct3      (funct3),
    .i_op5         (op[5]),
    .i_funct7b5    (funct7b5),
    .o_alu_control (ALUControl)
  );

  // Branch resolves in the same cycle the ALU produces zero.
  assign PCWrite  = (w_pc_update | (w_branch & zero)) & rst_n;
  assign IRWrite  = w_irwrite  & rst_n;
  assign RegWrite = w_regwrite & rst_n;
  assign MemWrite = w_memwrite & rst_n;
  assign illegal  = w_illegal  & rst_n;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: stimulus pushes per-cycle expected outputs derived from
// instruction step sequences; a negedge monitor pops and compares.
module tb_multicycle_controller;

  typedef struct packed {
    logic [2:0] alu;
    logic [1:0] sa, sb, rs, imm;
    logic adr, irw, pcw, rw, mw, ill;
  } out_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic [2:0] ALUControl;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
  logic       AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, illegal;

  int checks = 0;
  int errors = 0;
  out_t  exp_q[$];
  string name_q[$];

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .ALUControl(ALUControl), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite), .illegal(illegal)
  );

  function automatic out_t sample();
    return {ALUControl, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, AdrSrc,
            IRWrite, PCWrite, RegWrite, MemWrite, illegal};
  endfunction

  function automatic logic [2:0] funct_alu(logic [6:0] o, logic [2:0] f3, logic f7);
    case (f3)
      3'b000:  return (o == 7'b0110011 && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b111;
    endcase
  endfunction

  // Expected outputs for one named step of an instruction.
  function automatic out_t model(string step, logic [6:0] o, logic [2:0] f3,
                                 logic f7, logic z);
    out_t e;
    e = '0;
    if (o == 7'b0100011)      e.imm = 2'b01;
    else if (o == 7'b1100011) e.imm = 2'b10;
    else if (o == 7'b1101111) e.imm = 2'b11;
    case (step)
      "RESET":    begin e.sb = 2'b10; e.rs = 2'b10; end
      "FETCH":    begin e.sb = 2'b10; e.rs = 2'b10; e.irw = 1; e.pcw = 1; end
      "DECODE":   begin e.sa = 2'b01; e.sb = 2'b01; end
      "MEMADR":   begin e.sa = 2'b10; e.sb = 2'b01; end
      "EXECI":    begin e.sa = 2'b10; e.sb = 2'b01; e.alu = funct_alu(o, f3, f7); end
      "EXECR":    begin e.sa = 2'b10; e.alu = funct_alu(o, f3, f7); end
      "MEMREAD":  e.adr = 1;
      "MEMWB":    begin e.rs = 2'b01; e.rw = 1; end
      "MEMWRITE": begin e.adr = 1; e.mw = 1; end
      "ALUWB":    e.rw = 1;
      "BEQ":      begin e.sa = 2'b10; e.alu = 3'b001; e.pcw = z; end
      "JAL":      begin e.sa = 2'b01; e.sb = 2'b10; e.pcw = 1; end
      "ERROR":    e.ill = 1;
      default:    e = '1;
    endcase
    return e;
  endfunction

  task automatic compare(input string nm, input out_t act, input out_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%05h expected=%05h op=%b f3=%b", nm, act, exp, op, funct3);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) compare(name_q.pop_front(), sample(), exp_q.pop_front());
  end

  // Called at posedge+1 while the DUT is in the step; zf<0 randomizes zero.
  task automatic step_cycle(input string s, input int zf);
    zero = (zf < 0) ? 1'($urandom_range(0, 1)) : 1'(zf);
    exp_q.push_back(model(s, op, funct3, funct7b5, zero));
    name_q.push_back(s);
    @(posedge clk); #1;
  endtask

  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input int zf);
    string seq[$];
    case (o)
      7'b0000011: seq = '{"FETCH", "DECODE", "MEMADR", "MEMREAD", "MEMWB"};
      7'b0100011: seq = '{"FETCH", "DECODE", "MEMADR", "MEMWRITE"};
      7'b0110011: seq = '{"FETCH", "DECODE", "EXECR", "ALUWB"};
      7'b0010011: seq = '{"FETCH", "DECODE", "EXECI", "ALUWB"};
      7'b1100011: seq = '{"FETCH", "DECODE", "BEQ"};
      7'b1101111: seq = '{"FETCH", "DECODE", "JAL", "ALUWB"};
      default:    seq = '{"FETCH", "DECODE", "ERROR"};
    endcase
    op = o; funct3 = f3; funct7b5 = f7;
    foreach (seq[i]) step_cycle(seq[i], zf);
  endtask

  logic [6:0] ops[6] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                         7'b1100011, 7'b1101111};
  logic [2:0] f3s[6] = '{3'b000, 3'b010, 3'b110, 3'b111, 3'b100, 3'b001};

  initial begin
    rst_n = 1'b0; op = 7'b0000011; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b0;
    #3 compare("reset_outputs", sample(), model("RESET", op, funct3, funct7b5, zero));
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    run_instr(7'b0000011, 3'b010, 1'b0, -1);
    run_instr(7'b0110011, 3'b000, 1'b1, -1);
    run_instr(7'b0110011, 3'b000, 1'b0, -1);
    run_instr(7'b0010011, 3'b000, 1'b1, -1);
    run_instr(7'b1100011, 3'b000, 1'b0, 1);
    run_instr(7'b1100011, 3'b000, 1'b0, 0);
    run_instr(7'b0110011, 3'b100, 1'b0, -1);
    run_instr(7'b1101111, 3'b000, 1'b0, -1);

    for (int n = 0; n < 60; n++)
      run_instr(ops[$urandom_range(0, 5)], f3s[$urandom_range(0, 5)],
                1'($urandom_range(0, 1)), -1);

    // Asynchronous reset while in MEMWRITE.
    op = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0;
    step_cycle("FETCH", -1); step_cycle("DECODE", -1); step_cycle("MEMADR", -1);
    compare("memwrite_before_reset", sample(), model("MEMWRITE", op, funct3, funct7b5, zero));
    #1 rst_n = 1'b0;
    #1 compare("memwrite_async_reset", sample(), model("RESET", op, funct3, funct7b5, zero));
    @(posedge clk); #1;
    compare("held_in_reset", sample(), model("RESET", op, funct3, funct7b5, zero));
    rst_n = 1'b1;
    run_instr(7'b0010011, 3'b111, 1'b1, -1);

    // Unsupported opcode traps until reset.
    op = 7'b0000000; funct3 = 3'($urandom_range(0, 7)); funct7b5 = 1'b0;
    step_cycle("FETCH", -1); step_cycle("DECODE", -1);
    for (int n = 0; n < 10; n++) step_cycle("ERROR", -1);
    rst_n = 1'b0;
    #1 compare("error_cleared_by_reset", sample(), model("RESET", op, funct3, funct7b5, zero));
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_instr(7'b0000011, 3'b010, 1'b0, -1);
    run_instr(7'b1100011, 3'b000, 1'b0, -1);

    for (int n = 0; n < 5 && exp_q.size() > 0; n++) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d expected=0 pending", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
